// File: rtl/voice_allocator.sv
`default_nettype none
// ============================================================================
// Module   : voice_allocator
// Purpose  : Polyphonic note scheduler. Takes note-on/off events, assigns
//            each note to a voice slot and steals the oldest voice when all
//            are busy. Drives per-voice phase increments and gate bits.
//            Stolen or retriggered voices get a gate-low gap so the
//            envelope restarts its attack.
// Revision : 1.0 - initial release
// ============================================================================
module voice_allocator #(
  parameter int VOICES   = 4,
  parameter int FREQBITS = 32,
  parameter int NOTEBITS = 7,
  parameter int AGEBITS  = 8,
  parameter int RETRIG   = 8192
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         ev_valid,
  output logic                         ev_ready,
  input  logic                         ev_on,
  input  logic [NOTEBITS-1:0]          ev_note,
  input  logic [FREQBITS-1:0]          ev_freq,
  input  logic                         all_off,
  output logic [VOICES*FREQBITS-1:0]   freq,
  output logic [VOICES-1:0]            gate,
  output logic                         assign_valid,
  output logic [$clog2(VOICES)-1:0]    assign_voice,
  output logic                         assign_stolen
);

  localparam int                 IDXW      = $clog2(VOICES);
  localparam int                 HOLDW     = (RETRIG > 1) ? $clog2(RETRIG) : 1;
  localparam logic [HOLDW-1:0]   HOLD_INIT = HOLDW'(RETRIG - 1);
  localparam logic [IDXW-1:0]    LAST_IDX  = IDXW'(VOICES - 1);
  localparam logic [AGEBITS-1:0] AGE_MAX   = '1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SCAN   = 2'd1,
    S_COMMIT = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Latched event
  logic                on_q, on_d;
  logic [NOTEBITS-1:0] note_in_q, note_in_d;
  logic [FREQBITS-1:0] freq_in_q, freq_in_d;

  // Scan bookkeeping: one voice examined per cycle
  logic [IDXW-1:0]     idx_q, idx_d;
  logic                ret_found_q, ret_found_d;
  logic [IDXW-1:0]     ret_idx_q, ret_idx_d;
  logic                free_found_q, free_found_d;
  logic [IDXW-1:0]     free_idx_q, free_idx_d;
  logic [AGEBITS-1:0]  free_age_q, free_age_d;
  logic [IDXW-1:0]     max_idx_q, max_idx_d;
  logic [AGEBITS-1:0]  max_age_q, max_age_d;
  logic [VOICES-1:0]   off_mask_q, off_mask_d;

  // Retrigger/steal gap
  logic [IDXW-1:0]     chosen_q, chosen_d;
  logic [HOLDW-1:0]    hold_q, hold_d;

  // Per-voice state
  logic [NOTEBITS-1:0] note_q  [VOICES];
  logic [NOTEBITS-1:0] note_d  [VOICES];
  logic [AGEBITS-1:0]  age_q   [VOICES];
  logic [AGEBITS-1:0]  age_d   [VOICES];
  logic [FREQBITS-1:0] vfreq_q [VOICES];
  logic [FREQBITS-1:0] vfreq_d [VOICES];
  logic [VOICES-1:0]   gate_q, gate_d;

  // Assignment report
  logic                av_q, av_d;
  logic [IDXW-1:0]     avoice_q, avoice_d;
  logic                astolen_q, astolen_d;

  // Final candidate selection from the scan results
  logic [IDXW-1:0]     pick;
  logic                pick_free;

  assign ev_ready      = (state_q == S_IDLE) && !all_off;
  assign gate          = gate_q;
  assign assign_valid  = av_q;
  assign assign_voice  = avoice_q;
  assign assign_stolen = astolen_q;

  for (genvar gi = 0; gi < VOICES; gi++) begin : g_freq
    assign freq[gi*FREQBITS +: FREQBITS] = vfreq_q[gi];
  end

  // FSM state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state, scan evaluation and commit/hold updates
  always_comb begin
    state_d      = state_q;
    on_d         = on_q;
    note_in_d    = note_in_q;
    freq_in_d    = freq_in_q;
    idx_d        = idx_q;
    ret_found_d  = ret_found_q;
    ret_idx_d    = ret_idx_q;
    free_found_d = free_found_q;
    free_idx_d   = free_idx_q;
    free_age_d   = free_age_q;
    max_idx_d    = max_idx_q;
    max_age_d    = max_age_q;
    off_mask_d   = off_mask_q;
    chosen_d     = chosen_q;
    hold_d       = hold_q;
    note_d       = note_q;
    age_d        = age_q;
    vfreq_d      = vfreq_q;
    gate_d       = gate_q;
    av_d         = 1'b0;
    avoice_d     = avoice_q;
    astolen_d    = astolen_q;

    // Retrigger beats free voice, free voice beats steal
    pick      = max_idx_q;
    pick_free = 1'b0;
    if (ret_found_q) begin
      pick = ret_idx_q;
    end else if (free_found_q) begin
      pick      = free_idx_q;
      pick_free = 1'b1;
    end

    if (all_off) begin
      // Panic: silence everything and drop any in-flight event
      gate_d  = '0;
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ev_valid) begin
            state_d      = S_SCAN;
            on_d         = ev_on;
            note_in_d    = ev_note;
            freq_in_d    = ev_freq;
            idx_d        = '0;
            ret_found_d  = 1'b0;
            ret_idx_d    = '0;
            free_found_d = 1'b0;
            free_idx_d   = '0;
            free_age_d   = '0;
            max_idx_d    = '0;
            max_age_d    = '0;
            off_mask_d   = '0;
          end
        end
        S_SCAN: begin
          if (gate_q[idx_q] && (note_q[idx_q] == note_in_q)) begin
            off_mask_d[idx_q] = 1'b1;
            if (!ret_found_q) begin
              ret_found_d = 1'b1;
              ret_idx_d   = idx_q;
            end
          end
          // Strict compares keep ties at the lowest index
          if (!gate_q[idx_q] && (!free_found_q || (age_q[idx_q] > free_age_q))) begin
            free_found_d = 1'b1;
            free_idx_d   = idx_q;
            free_age_d   = age_q[idx_q];
          end
          if (age_q[idx_q] > max_age_q) begin
            max_idx_d = idx_q;
            max_age_d = age_q[idx_q];
          end
          if (idx_q == LAST_IDX) state_d = S_COMMIT;
          else                   idx_d   = idx_q + 1'b1;
        end
        S_COMMIT: begin
          state_d = S_IDLE;
          if (on_q) begin
            vfreq_d[pick] = freq_in_q;
            note_d[pick]  = note_in_q;
            gate_d[pick]  = pick_free;
            for (int i = 0; i < VOICES; i++) begin
              if (IDXW'(i) == pick)        age_d[i] = '0;
              else if (age_q[i] != AGE_MAX) age_d[i] = age_q[i] + 1'b1;
            end
            av_d      = 1'b1;
            avoice_d  = pick;
            astolen_d = !ret_found_q && !free_found_q;
            chosen_d  = pick;
            if (!pick_free) begin
              hold_d  = HOLD_INIT;
              state_d = S_HOLD;
            end
          end else begin
            gate_d = gate_q & ~off_mask_q;
          end
        end
        S_HOLD: begin
          if (hold_q == '0) begin
            gate_d[chosen_q] = 1'b1;
            state_d          = S_IDLE;
          end else begin
            hold_d = hold_q - 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Datapath and per-voice registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      on_q         <= 1'b0;
      note_in_q    <= '0;
      freq_in_q    <= '0;
      idx_q        <= '0;
      ret_found_q  <= 1'b0;
      ret_idx_q    <= '0;
      free_found_q <= 1'b0;
      free_idx_q   <= '0;
      free_age_q   <= '0;
      max_idx_q    <= '0;
      max_age_q    <= '0;
      off_mask_q   <= '0;
      chosen_q     <= '0;
      hold_q       <= '0;
      for (int i = 0; i < VOICES; i++) begin
        note_q[i]  <= '0;
        age_q[i]   <= '0;
        vfreq_q[i] <= '0;
      end
      gate_q       <= '0;
      av_q         <= 1'b0;
      avoice_q     <= '0;
      astolen_q    <= 1'b0;
    end else begin
      on_q         <= on_d;
      note_in_q    <= note_in_d;
      freq_in_q    <= freq_in_d;
      idx_q        <= idx_d;
      ret_found_q  <= ret_found_d;
      ret_idx_q    <= ret_idx_d;
      free_found_q <= free_found_d;
      free_idx_q   <= free_idx_d;
      free_age_q   <= free_age_d;
      max_idx_q    <= max_idx_d;
      max_age_q    <= max_age_d;
      off_mask_q   <= off_mask_d;
      chosen_q     <= chosen_d;
      hold_q       <= hold_d;
      note_q       <= note_d;
      age_q        <= age_d;
      vfreq_q      <= vfreq_d;
      gate_q       <= gate_d;
      av_q         <= av_d;
      avoice_q     <= avoice_d;
      astolen_q    <= astolen_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_voice_allocator.sv
`default_nettype none
// ============================================================================
// Module   : tb_voice_allocator
// Purpose  : Scoreboard bench for voice_allocator. A reference model of the
//            voice table predicts each event's assignment, timing and final
//            gate/freq state; a monitor checks assignment pulses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_voice_allocator;

  localparam int VOICES   = 4;
  localparam int FREQBITS = 32;
  localparam int NOTEBITS = 7;
  localparam int AGEBITS  = 8;
  localparam int RETRIG   = 16;
  localparam int AGE_SAT  = (1 << AGEBITS) - 1;

  logic                       clk;
  logic                       resetn;
  logic                       ev_valid;
  logic                       ev_ready;
  logic                       ev_on;
  logic [NOTEBITS-1:0]        ev_note;
  logic [FREQBITS-1:0]        ev_freq;
  logic                       all_off;
  logic [VOICES*FREQBITS-1:0] freq;
  logic [VOICES-1:0]          gate;
  logic                       assign_valid;
  logic [1:0]                 assign_voice;
  logic                       assign_stolen;

  voice_allocator #(
    .VOICES(VOICES), .FREQBITS(FREQBITS), .NOTEBITS(NOTEBITS),
    .AGEBITS(AGEBITS), .RETRIG(RETRIG)
  ) dut (
    .clk(clk), .resetn(resetn),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_on(ev_on),
    .ev_note(ev_note), .ev_freq(ev_freq), .all_off(all_off),
    .freq(freq), .gate(gate),
    .assign_valid(assign_valid), .assign_voice(assign_voice),
    .assign_stolen(assign_stolen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [1:0] voice;
    logic       stolen;
  } exp_t;
  exp_t sb_q[$];

  // Reference model of the voice table
  int                  m_note [VOICES];
  int                  m_age  [VOICES];
  logic [FREQBITS-1:0] m_freq [VOICES];
  logic [VOICES-1:0]   m_gate;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [VOICES*FREQBITS-1:0] model_bus();
    logic [VOICES*FREQBITS-1:0] b;
    for (int i = 0; i < VOICES; i++) b[i*FREQBITS +: FREQBITS] = m_freq[i];
    return b;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < VOICES; i++) begin
      m_note[i] = 0;
      m_age[i]  = 0;
      m_freq[i] = '0;
    end
    m_gate = '0;
  endtask

  // Applies one event to the model and reports the expected outcome
  task automatic predict(input bit on, input int note, input logic [FREQBITS-1:0] f,
                         output int v, output bit stolen, output bit pulse, output bit hold);
    int best;
    v = -1; stolen = 0; pulse = 0; hold = 0;
    if (on) begin
      for (int i = 0; i < VOICES; i++)
        if (v < 0 && m_gate[i] && m_note[i] == note) v = i;
      if (v >= 0) begin
        hold = 1;
      end else begin
        best = -1;
        for (int i = 0; i < VOICES; i++)
          if (!m_gate[i] && (best < 0 || m_age[i] > m_age[best])) best = i;
        if (best >= 0) begin
          v = best;
        end else begin
          best = 0;
          for (int i = 1; i < VOICES; i++)
            if (m_age[i] > m_age[best]) best = i;
          v = best; hold = 1; stolen = 1;
        end
      end
      pulse = 1;
      for (int i = 0; i < VOICES; i++) begin
        if (i == v)                m_age[i] = 0;
        else if (m_age[i] < AGE_SAT) m_age[i] = m_age[i] + 1;
      end
      m_freq[v] = f;
      m_note[v] = note;
      m_gate[v] = 1'b1;
    end else begin
      for (int i = 0; i < VOICES; i++)
        if (m_gate[i] && m_note[i] == note) m_gate[i] = 1'b0;
    end
  endtask

  // Presents an event and waits (bounded) for its handshake edge
  task automatic handshake(input bit on, input int note, input logic [FREQBITS-1:0] f,
                           output bit ok);
    ok = 0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (ev_ready) begin
        ev_valid = 1'b1;
        ev_on    = on;
        ev_note  = NOTEBITS'(note);
        ev_freq  = f;
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      chk("handshake_timeout", 0, 1);
    end else begin
      @(posedge clk);
      #1 ev_valid = 1'b0;
    end
  endtask

  task automatic do_event(input bit on, input int note, input logic [FREQBITS-1:0] f);
    int v, lat, exp_lat;
    bit stolen, pulse, hold, ok;
    logic [VOICES-1:0] gate_before;
    gate_before = m_gate;
    predict(on, note, f, v, stolen, pulse, hold);
    exp_lat = VOICES + 1 + (hold ? RETRIG : 0);
    handshake(on, note, f, ok);
    if (!ok) return;
    if (pulse) sb_q.push_back('{voice: 2'(v), stolen: stolen});
    lat = -1;
    for (int n = 1; n <= exp_lat + 40; n++) begin
      @(posedge clk);
      #1;
      if (n == VOICES) chk("gate_before_commit", gate, gate_before);
      if (n == VOICES + 1) begin
        chk("assign_valid_at_commit", assign_valid, pulse);
        if (on) chk("freq_at_commit", freq[v*FREQBITS +: FREQBITS], f);
        if (hold) chk("gap_gate_low_start", gate[v], 0);
      end
      if (hold && n == VOICES + RETRIG) chk("gap_gate_low_end", gate[v], 0);
      if (ev_ready) begin
        lat = n;
        break;
      end
    end
    chk("ready_latency", lat, exp_lat);
    chk("gate_after_event", gate, m_gate);
    chk("freq_after_event", freq, model_bus());
  endtask

  // Starts a retrigger/steal and aborts it mid-gap with all_off or reset
  task automatic abort_hold(input bit use_reset, input int note, input logic [FREQBITS-1:0] f);
    int v;
    bit stolen, pulse, hold, ok;
    predict(1'b1, note, f, v, stolen, pulse, hold);
    chk("abort_expects_hold", hold, 1);
    handshake(1'b1, note, f, ok);
    if (!ok) return;
    sb_q.push_back('{voice: 2'(v), stolen: stolen});
    repeat (VOICES + 3) @(posedge clk);
    #1 chk("hold_gate_low", gate[v], 0);
    @(negedge clk);
    if (use_reset) begin
      resetn = 1'b0;
      model_reset();
      #1;
      chk("reset_gate", gate, 0);
      chk("reset_freq", freq, 0);
      chk("reset_ready", ev_ready, 1);
      @(negedge clk);
      resetn = 1'b1;
    end else begin
      all_off = 1'b1;
      m_gate  = '0;
      @(posedge clk);
      #1;
      chk("all_off_gate", gate, 0);
      chk("all_off_ready", ev_ready, 0);
    end
    repeat (RETRIG + 4) @(posedge clk);
    #1;
    chk("aborted_gate_stays_low", gate, 0);
    if (!use_reset) begin
      chk("all_off_ready_held", ev_ready, 0);
      chk("all_off_freq_kept", freq, model_bus());
      @(negedge clk);
      all_off = 1'b0;
      #1 chk("ready_after_all_off", ev_ready, 1);
    end
  endtask

  // Monitor: every assignment pulse must match the oldest expectation
  initial begin
    forever begin
      exp_t e;
      @(negedge clk);
      if (resetn && assign_valid) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_assign_pulse", 1, 0);
        end else begin
          e = sb_q.pop_front();
          chk("assign_voice", assign_voice, e.voice);
          chk("assign_stolen", assign_stolen, e.stolen);
        end
      end
    end
  end

  initial begin
    resetn   = 1'b0;
    ev_valid = 1'b0;
    ev_on    = 1'b0;
    ev_note  = '0;
    ev_freq  = '0;
    all_off  = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_gate", gate, 0);
    chk("reset_freq", freq, 0);
    chk("reset_assign_valid", assign_valid, 0);
    chk("reset_assign_voice", assign_voice, 0);
    chk("reset_ready", ev_ready, 1);
    @(negedge clk);
    resetn = 1'b1;

    // First note, fill the rest, then steal the oldest
    do_event(1'b1, 60, 32'h0000_0888);
    do_event(1'b1, 62, 32'h0000_0999);
    do_event(1'b1, 64, 32'h0000_0aaa);
    do_event(1'b1, 67, 32'h0000_0bbb);
    do_event(1'b1, 72, 32'h0000_1111);
    // Note-off on voice 1, then a note-off that matches nothing
    do_event(1'b0, 62, 32'h0);
    do_event(1'b0, 50, 32'h0);
    // Retrigger a sounding note
    do_event(1'b1, 64, 32'h0000_0abc);

    // Random traffic over a narrow note range to force collisions
    for (int k = 0; k < 40; k++) begin
      bit on;
      on = ($urandom_range(0, 3) != 0);
      do_event(on, 60 + int'($urandom_range(0, 5)), $urandom);
    end

    // Panic during a retrigger gap
    do_event(1'b1, 90, 32'h0000_2222);
    abort_hold(1'b0, 90, 32'h0000_3333);

    // Reset during a steal gap
    do_event(1'b1, 80, 32'h0000_4000);
    do_event(1'b1, 81, 32'h0000_4100);
    do_event(1'b1, 82, 32'h0000_4200);
    do_event(1'b1, 83, 32'h0000_4300);
    abort_hold(1'b1, 84, 32'h0000_4400);

    // Fresh start after reset lands on voice 0
    do_event(1'b1, 60, 32'h0000_0888);

    repeat (3) @(posedge clk);
    #1 chk("scoreboard_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
